// File: rtl/cu_sequencer.sv
// Control-unit sequence counter: walks FETCH1..FETCH3, dispatches on the opcode
// into the execute states, and counts retired instructions.
module cu_sequencer #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clear,
  input  logic [1:0]       ir_opcode,
  output logic [N-1:0]     counter_value,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [N-1:0] S_FETCH1 = N'(0);
  localparam logic [N-1:0] S_FETCH2 = N'(1);
  localparam logic [N-1:0] S_FETCH3 = N'(2);
  localparam logic [N-1:0] S_ADD1   = N'(3);
  localparam logic [N-1:0] S_ADD2   = N'(4);
  localparam logic [N-1:0] S_AND1   = N'(5);
  localparam logic [N-1:0] S_AND2   = N'(6);
  localparam logic [N-1:0] S_JMP1   = N'(7);
  localparam logic [N-1:0] S_INC1   = N'(8);

  logic [N-1:0]     r_state;
  logic             r_done;
  logic [CNT_W-1:0] r_count;

  logic [N-1:0]     w_next_state;
  logic             w_terminal;
  logic             w_retire;
  logic             w_done_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  // State and registered outputs; reset dominates clear and run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH1;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_done_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state: hold when stalled, opcode is only consulted when leaving FETCH3.
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = S_FETCH1;
    end else if (run) begin
      case (r_state)
        S_FETCH1: w_next_state = S_FETCH2;
        S_FETCH2: w_next_state = S_FETCH3;
        S_FETCH3: begin
          case (ir_opcode)
            2'b00:   w_next_state = S_ADD1;
            2'b01:   w_next_state = S_AND1;
            2'b10:   w_next_state = S_JMP1;
            default: w_next_state = S_INC1;
          endcase
        end
        S_ADD1:  w_next_state = S_ADD2;
        S_ADD2:  w_next_state = S_FETCH1;
        S_AND1:  w_next_state = S_AND2;
        S_AND2:  w_next_state = S_FETCH1;
        S_JMP1:  w_next_state = S_FETCH1;
        S_INC1:  w_next_state = S_FETCH1;
        default: w_next_state = S_FETCH1;
      endcase
    end
  end

  // Retire only on an advancing step out of a terminal state; illegal-index recovery never counts.
  always_comb begin
    w_terminal  = 1'b0;
    w_retire    = 1'b0;
    w_done_nxt  = 1'b0;
    w_count_nxt = r_count;
    w_terminal  = (r_state == S_ADD2) || (r_state == S_AND2) ||
                  (r_state == S_JMP1) || (r_state == S_INC1);
    w_retire    = run && !clear && w_terminal;
    w_done_nxt  = w_retire;
    w_count_nxt = r_count + CNT_W'(w_retire);
  end

  assign counter_value = r_state;
  assign instr_done    = r_done;
  assign instr_count   = r_count;

endmodule

// File: tb/tb_cu_sequencer.sv
// Scoreboard bench for cu_sequencer: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cu_sequencer;

  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             run;
  logic             clear;
  logic [1:0]       ir_opcode;
  logic [N-1:0]     counter_value;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;

  typedef struct {
    logic [N-1:0]     cv;
    logic             done;
    logic [CNT_W-1:0] cnt;
    int               step;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_no  = 0;

  cu_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .clear         (clear),
    .ir_opcode     (ir_opcode),
    .counter_value (counter_value),
    .instr_done    (instr_done),
    .instr_count   (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int step, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, step, got, want);
    end
  endtask

  // Monitor: outputs are presented every cycle, compare against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("counter_value", e.step, int'(counter_value), int'(e.cv));
      check("instr_done",    e.step, int'(instr_done),    int'(e.done));
      check("instr_count",   e.step, int'(instr_count),   int'(e.cnt));
    end
  end

  // One clock of stimulus plus the expected outputs after that edge.
  task automatic cyc(input logic r, input logic c, input logic [1:0] op,
                     input int cv, input int dn, input int cnt);
    exp_t e;
    run       = r;
    clear     = c;
    ir_opcode = op;
    @(posedge clk);
    #1;
    step_no++;
    e.cv   = N'(cv);
    e.done = dn[0];
    e.cnt  = CNT_W'(cnt);
    e.step = step_no;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n     = 1'b0;
    run       = 1'b0;
    clear     = 1'b0;
    ir_opcode = 2'b00;
    #2;
    check("reset_cv",    0, int'(counter_value), 0);
    check("reset_done",  0, int'(instr_done),    0);
    check("reset_count", 0, int'(instr_count),   0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ADD then AND; opcode changes inside ADD1/ADD2 are ignored
    cyc(1, 0, 2'd0, 1, 0, 0);
    cyc(1, 0, 2'd0, 2, 0, 0);
    cyc(1, 0, 2'd0, 3, 0, 0);
    cyc(1, 0, 2'd1, 4, 0, 0);
    cyc(1, 0, 2'd1, 0, 1, 1);
    cyc(1, 0, 2'd1, 1, 0, 1);
    cyc(1, 0, 2'd1, 2, 0, 1);
    cyc(1, 0, 2'd1, 5, 0, 1);
    cyc(1, 0, 2'd1, 6, 0, 1);
    cyc(1, 0, 2'd2, 0, 1, 2);

    // JMP then INC, with opcode toggling in states 0, 1, 7 and 8
    cyc(1, 0, 2'd3, 1, 0, 2);
    cyc(1, 0, 2'd0, 2, 0, 2);
    cyc(1, 0, 2'd2, 7, 0, 2);
    cyc(1, 0, 2'd0, 0, 1, 3);
    cyc(1, 0, 2'd1, 1, 0, 3);
    cyc(1, 0, 2'd2, 2, 0, 3);
    cyc(1, 0, 2'd3, 8, 0, 3);
    cyc(1, 0, 2'd0, 0, 1, 4);

    // Stall three cycles in AND1
    cyc(1, 0, 2'd1, 1, 0, 4);
    cyc(1, 0, 2'd1, 2, 0, 4);
    cyc(1, 0, 2'd1, 5, 0, 4);
    cyc(0, 0, 2'd1, 5, 0, 4);
    cyc(0, 0, 2'd1, 5, 0, 4);
    cyc(0, 0, 2'd1, 5, 0, 4);
    cyc(1, 0, 2'd1, 6, 0, 4);
    cyc(1, 0, 2'd1, 0, 1, 5);

    // Stall in FETCH3 while opcode moves 00 -> 11; sample happens on the run edge
    cyc(1, 0, 2'd0, 1, 0, 5);
    cyc(1, 0, 2'd0, 2, 0, 5);
    cyc(0, 0, 2'd0, 2, 0, 5);
    cyc(0, 0, 2'd3, 2, 0, 5);
    cyc(1, 0, 2'd3, 8, 0, 5);
    cyc(1, 0, 2'd3, 0, 1, 6);

    // Stall in a terminal state: no pulse, no count until it actually retires
    cyc(1, 0, 2'd2, 1, 0, 6);
    cyc(1, 0, 2'd2, 2, 0, 6);
    cyc(1, 0, 2'd2, 7, 0, 6);
    cyc(0, 0, 2'd2, 7, 0, 6);
    cyc(1, 0, 2'd2, 0, 1, 7);

    // Clear in ADD1, INC1 and ADD2; none of these are counted
    cyc(1, 0, 2'd0, 1, 0, 7);
    cyc(1, 0, 2'd0, 2, 0, 7);
    cyc(1, 0, 2'd0, 3, 0, 7);
    cyc(1, 1, 2'd0, 0, 0, 7);
    cyc(1, 0, 2'd3, 1, 0, 7);
    cyc(1, 0, 2'd3, 2, 0, 7);
    cyc(1, 0, 2'd3, 8, 0, 7);
    cyc(1, 1, 2'd3, 0, 0, 7);
    cyc(0, 1, 2'd3, 0, 0, 7);
    cyc(1, 0, 2'd0, 1, 0, 7);
    cyc(1, 0, 2'd0, 2, 0, 7);
    cyc(1, 0, 2'd0, 3, 0, 7);
    cyc(1, 0, 2'd0, 4, 0, 7);
    cyc(1, 1, 2'd0, 0, 0, 7);

    // Reset asynchronously while in ADD2
    cyc(1, 0, 2'd0, 1, 0, 7);
    cyc(1, 0, 2'd0, 2, 0, 7);
    cyc(1, 0, 2'd0, 3, 0, 7);
    cyc(1, 0, 2'd0, 4, 0, 7);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_cv",    step_no, int'(counter_value), 0);
    check("async_rst_done",  step_no, int'(instr_done),    0);
    check("async_rst_count", step_no, int'(instr_count),   0);
    @(posedge clk);
    #1;
    check("rst_held_cv", step_no, int'(counter_value), 0);
    rst_n = 1'b1;

    // Sixteen INCs from a fresh count: wraps 15 -> 0 with the pulse still present
    for (int k = 0; k < 16; k++) begin
      cyc(1, 0, 2'd3, 1, 0, k);
      cyc(1, 0, 2'd3, 2, 0, k);
      cyc(1, 0, 2'd3, 8, 0, k);
      cyc(1, 0, 2'd3, 0, 1, (k + 1) % 16);
    end
    cyc(1, 0, 2'd3, 1, 0, 0);
    run = 1'b0;

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
    check("queue_drained", step_no, exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
